// File: rtl/spi_pkg.sv
// Shared types, mode constants and sizing helper for the SPI master core.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} spi_state_t;

  // Modes encoded as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int ss_width(input int num_ss);
    return (num_ss > 1) ? $clog2(num_ss) : 1;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period divider plus phase counter. Strobes fire in the clk
// cycle whose registered update produces the corresponding SCK edge.
module spi_sck_gen import spi_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             load,
  input  logic             load_cpol,
  input  logic [DIV_W-1:0] cdiv,
  output logic             sck,
  output logic             lead_stb,
  output logic             trail_stb,
  output logic             last_trail,
  output logic             xfer_end,
  output logic             trail_end
);

  localparam int PH_W = $clog2(2 * DATA_W + 2);
  localparam logic [PH_W-1:0] PH_LAST_EDGE = PH_W'(2 * DATA_W - 1);
  localparam logic [PH_W-1:0] PH_XFER_END  = PH_W'(2 * DATA_W);
  localparam logic [PH_W-1:0] PH_TRAIL     = PH_W'(2 * DATA_W + 1);

  logic [DIV_W-1:0] cnt;
  logic [PH_W-1:0]  phase;
  logic             half_end;
  logic             edge_ph;

  // Phase 0 is LEAD, phases 1..2*DATA_W are XFER half-periods, last is TRAIL.
  assign half_end   = en && (cnt == cdiv);
  assign edge_ph    = (phase <= PH_LAST_EDGE);
  assign lead_stb   = half_end && edge_ph && !phase[0];
  assign trail_stb  = half_end && edge_ph && phase[0];
  assign last_trail = trail_stb && (phase == PH_LAST_EDGE);
  assign xfer_end   = half_end && (phase == PH_XFER_END);
  assign trail_end  = half_end && (phase == PH_TRAIL);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt   <= '0;
      phase <= '0;
      sck   <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      phase <= '0;
      sck   <= load_cpol;
    end else if (!en) begin
      cnt   <= '0;
      phase <= '0;
    end else if (half_end) begin
      cnt   <= '0;
      phase <= trail_end ? '0 : phase + 1'b1;
      if (edge_ph) sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// Parametrised SPI master: control FSM, transmit/receive shift registers and
// slave-select decode around the SCK generator.
module spi_master_core import spi_pkg::*; #(
  parameter int  DATA_W = 8,
  parameter int  DIV_W  = 8,
  parameter int  NUM_SS = 1,
  localparam int SS_W   = ss_width(NUM_SS)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              mlb,
  input  logic [DIV_W-1:0]  cdiv,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] tdat,
  input  logic              din,
  output logic              sck,
  output logic [NUM_SS-1:0] ss_n,
  output logic              dout,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);

  spi_state_t        state;
  logic              cpha_reg;
  logic              mlb_reg;
  logic [DIV_W-1:0]  cdiv_reg;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [NUM_SS-1:0] ss_dec;
  logic              accept;
  logic              lead_stb, trail_stb, last_trail, xfer_end, trail_end;
  logic              tx_bit;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_in;

  assign accept   = (state == IDLE) && start;
  assign tx_bit   = mlb_reg ? tx_sr[DATA_W-1] : tx_sr[0];
  assign tx_shift = mlb_reg ? (tx_sr << 1) : (tx_sr >> 1);
  assign rx_in    = mlb_reg ? {rx_sr[DATA_W-2:0], din} : {din, rx_sr[DATA_W-1:1]};

  // Out-of-range selects match no line, so the transfer runs with all ss_n high.
  for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss
    assign ss_dec[gi] = (ss_sel != SS_W'(gi));
  end

  spi_sck_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_sck_gen (
    .clk        (clk),
    .rstb       (rstb),
    .en         (state != IDLE),
    .load       (accept),
    .load_cpol  (cpol),
    .cdiv       (cdiv_reg),
    .sck        (sck),
    .lead_stb   (lead_stb),
    .trail_stb  (trail_stb),
    .last_trail (last_trail),
    .xfer_end   (xfer_end),
    .trail_end  (trail_end)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ss_n     <= '1;
      dout     <= 1'b1;
      rdata    <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpha_reg <= 1'b0;
      mlb_reg  <= 1'b0;
      cdiv_reg <= '0;
    end else begin
      done <= 1'b0;
      // cpha=0 samples on leading edges; cpha=1 drives on leading edges.
      if (lead_stb) begin
        if (!cpha_reg) begin
          rx_sr <= rx_in;
        end else begin
          dout  <= tx_bit;
          tx_sr <= tx_shift;
        end
      end
      if (trail_stb) begin
        if (cpha_reg) begin
          rx_sr <= rx_in;
        end else if (!last_trail) begin
          dout  <= tx_bit;
          tx_sr <= tx_shift;
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LEAD;
            busy     <= 1'b1;
            ss_n     <= ss_dec;
            cpha_reg <= cpha;
            mlb_reg  <= mlb;
            cdiv_reg <= cdiv;
            rx_sr    <= '0;
            if (!cpha) begin
              dout  <= mlb ? tdat[DATA_W-1] : tdat[0];
              tx_sr <= mlb ? (tdat << 1) : (tdat >> 1);
            end else begin
              dout  <= 1'b1;
              tx_sr <= tdat;
            end
          end
        end
        LEAD:  if (lead_stb) state <= XFER;
        XFER:  if (xfer_end) state <= TRAIL;
        TRAIL: begin
          if (trail_end) begin
            state <= IDLE;
            rdata <= rx_sr;
            done  <= 1'b1;
            busy  <= 1'b0;
            ss_n  <= '1;
            dout  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_core.md
# spi_master_core

Parametrised single-clock SPI master, successor to the team's fixed 8-bit SPI block. It adds configurable word width, a programmable clock divider, all four CPOL/CPHA modes, MSB/LSB-first selection and multiple slave selects. Every flop is clocked on `clk`; SCK is a registered output, never used as a clock. The block sits between the board controller FSM and the external SPI peripherals.

## Interface
- `DATA_W`, default 8: bits per transfer (≥2).
- `DIV_W`, default 8: width of `cdiv`.
- `NUM_SS`, default 1: number of slave-select lines; `SS_W = max(1, clog2(NUM_SS))`.
- `clk` in, 1: system clock, single clock domain.
- `rstb` in, 1: asynchronous active-low reset.
- `start` in, 1: transfer request, sampled in IDLE only.
- `cpol` in, 1: SCK idle level; latched at start.
- `cpha` in, 1: 0 = sample on leading edge, 1 = sample on trailing edge; latched at start.
- `mlb` in, 1: 1 = MSB first, 0 = LSB first; latched at start.
- `cdiv` in, DIV_W: half-period H = cdiv+1 clk cycles; latched at start.
- `ss_sel` in, SS_W: slave index; latched at start.
- `tdat` in, DATA_W: transmit word; latched at start.
- `din` in, 1: MISO.
- `sck` out, 1: serial clock.
- `ss_n` out, NUM_SS: active-low slave selects.
- `dout` out, 1: MOSI.
- `busy` out, 1: transfer in progress.
- `done` out, 1: one-cycle completion pulse.
- `rdata` out, DATA_W: received word, valid from `done` until the next `done`.

## Operation
- Reset values: `sck`=0, `ss_n`=all 1, `dout`=1, `busy`=0, `done`=0, `rdata`=0, state IDLE, latched cpol=0.
- States:
  - IDLE: `start`=1 latches all config and `tdat`, then moves to LEAD.
  - LEAD: lasts H cycles. Selected `ss_n` is low. For cpha=0, `dout` = first bit.
  - XFER: lasts 2·DATA_W half-periods of H cycles each. `sck` toggles at the end of each half-period; the first toggle is the leading edge.
  - TRAIL: lasts H cycles. `sck` is at cpol and `ss_n` is held low.
  - Return to IDLE.
- cpha=0: sample `din` on leading edges, shift `dout` on trailing edges except the last.
- cpha=1: shift `dout` on leading edges (first bit appears on the first leading edge), sample on trailing edges.
- `din` is captured in the clk cycle whose registered update drives the sampling SCK edge.
- Shift direction follows latched `mlb`:
  - MSB first: transmit from bit DATA_W-1; receive shifts in at the LSB.
  - LSB first: transmit from bit 0; receive shifts in at the MSB.
- `dout` returns to 1 in IDLE.
- Exit from TRAIL, in a single cycle: `rdata` loads the receive shift register, `done`=1, `busy`=0, and all `ss_n` go high.
- `ss_sel` ≥ NUM_SS: no `ss_n` asserts, but the transfer still runs and `done` still fires.
- `start` while `busy`=1 is ignored; there is no queueing.
- `start` in the `done` cycle is accepted (back-to-back transfers). `ss_n` is high for exactly that one cycle.
- Config inputs changing mid-transfer have no effect.
- Reset mid-transfer returns all outputs to reset values immediately. `done` is not pulsed and `rdata` is cleared.

## Timing
- `start` accepted at cycle t. `busy`=1 and `ss_n[sel]`=0 from t+1.
- First SCK edge at t+1+H.
- `done` at t+1+(2·DATA_W+2)·H.
  - Example: DATA_W=8, cdiv=0 gives 19 cycles.
- SCK period is 2H clk cycles; cdiv=0 gives clk/2.
- SCK duty cycle is exactly 50% and SCK is glitch-free.
- `sck` equals latched cpol in LEAD and TRAIL. In IDLE, `sck` equals cpol of the last transfer (0 after reset).

## Structure
- Package `spi_pkg`:
  - state enum (IDLE, LEAD, XFER, TRAIL);
  - mode constants SPI_MODE0–3 as {cpol,cpha};
  - function computing SS_W.
- Sub-module `spi_sck_gen`:
  - DIV_W half-period counter plus edge counter;
  - emits one-cycle `lead_stb` / `trail_stb` strobes and the registered `sck`;
  - enabled by the FSM, cleared in IDLE.
- Top level holds the FSM, the shift registers and the ss decode.

## Test plan
- DATA_W=8, cdiv=0, mode 0, mlb=1, tdat=0xA5, din looped to dout → `rdata`=0xA5, `done` exactly 19 cycles after `start`, 8 rising SCK edges.
- Mode 3, mlb=0, cdiv=3, slave model returning 0x5A → `rdata`=0x5A; `sck` idles 1 with period 8 clk; `dout` bit order on MOSI is tdat[0] first.
- NUM_SS=4, ss_sel=2 → only `ss_n[2]` low for the transfer; ss_sel=3 and ss_sel=0 checked likewise. Separately, NUM_SS=3 with ss_sel=3 → no `ss_n` low, `done` still fires.
- `start` pulsed mid-transfer → ignored, single `done`. `start` held through the `done` cycle → second transfer begins next cycle, with `ss_n` high for exactly one cycle.
- `rstb` low during XFER → same cycle: `ss_n`=all 1, `sck`=0, `busy`=0, `rdata`=0, no `done`.
- DATA_W=16, cdiv=255, mode 1, tdat=0xBEEF loopback → `rdata`=0xBEEF, latency (2·16+2)·256+1 cycles.
